sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_pkg.sv | 15 +
 rtl/sdram_tag_fifo.sv | 71 +++++++
 rtl/sdram_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM two-client port arbiter.
// Holds the arbiter FSM encoding, client index type and width defaults.
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 12;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    typedef logic client_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order tag FIFO recording which client owns each outstanding read.
// Push and pop may occur together; pop is ignored when empty.
module sdram_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    assign head  = mem_q[rp_q];

    // Next pointers, count and storage for this cycle's push/pop.
    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wp_q] = din;
            wp_d        = wp_q + 1'b1;
        end
        if (do_pop) begin
            rp_d = rp_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-client arbiter in front of a single-command SDRAM controller port.
// SDRAM_ARB_FIXED_PRIO_EN: client 0 always wins ties; else round-robin.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = SDRAM_ADDR_W,
    parameter int DATA_W    = SDRAM_DATA_W,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_rvalid,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_rvalid,
    input  logic              busy,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_gnt,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              err_orphan
);

    arb_state_e        state_q, state_d;
    client_t           win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rv0_q, rv0_d;
    logic              rv1_q, rv1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              err_q, err_d;

    logic    fifo_full, fifo_empty;
    client_t fifo_head;
    logic    elig0, elig1;
    client_t pick;
    logic    gnt_hit;
    logic    tag_push;

    assign elig0 = c0_req && (c0_we || !fifo_full);
    assign elig1 = c1_req && (c1_we || !fifo_full);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign pick = elig0 ? 1'b0 : 1'b1;
`else
    client_t prio_q, prio_d;
    assign pick = (elig0 && elig1) ? prio_q : elig1;
`endif

    assign wr_req  = (state_q == ISSUE) && we_q;
    assign rd_req  = (state_q == ISSUE) && !we_q;
    assign wr_addr = addr_q;
    assign rd_addr = addr_q;
    assign wr_data = wdata_q;

    assign gnt_hit  = (state_q == ISSUE) && (we_q ? wr_gnt : rd_gnt);
    assign tag_push = gnt_hit && !we_q;
    assign c0_gnt   = gnt_hit && (win_q == 1'b0);
    assign c1_gnt   = gnt_hit && (win_q == 1'b1);

    assign c0_rvalid  = rv0_q;
    assign c1_rvalid  = rv1_q;
    assign c0_rdata   = rdata0_q;
    assign c1_rdata   = rdata1_q;
    assign err_orphan = err_q;

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (1)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tag_push),
        .pop   (rd_valid),
        .din   (win_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Command FSM: latch the winner in IDLE, hold the request until granted.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        prio_d  = prio_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!busy && (elig0 || elig1)) begin
                    state_d = ISSUE;
                    win_d   = pick;
                    we_d    = pick ? c1_we : c0_we;
                    addr_d  = pick ? c1_addr : c0_addr;
                    wdata_d = pick ? c1_wdata : c0_wdata;
                end
            end
            ISSUE: begin
                if (gnt_hit) begin
                    state_d = IDLE;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                    prio_d  = ~win_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read return routing by head tag; unmatched data flags an orphan.
    always_comb begin
        rv0_d    = rd_valid && !fifo_empty && (fifo_head == 1'b0);
        rv1_d    = rd_valid && !fifo_empty && (fifo_head == 1'b1);
        rdata0_d = rv0_d ? rd_data : rdata0_q;
        rdata1_d = rv1_d ? rd_data : rdata1_q;
        err_d    = err_q || (rd_valid && fifo_empty);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            prio_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rv0_q    <= rv0_d;
            rv1_q    <= rv1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            err_q    <= err_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            prio_q   <= prio_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter (default 12/16/4 build).
// Read returns are checked against a scoreboard fed by a local tag model.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [11:0] c0_addr, c1_addr;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [15:0] c0_rdata, c1_rdata;
    logic        busy, wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
    logic [11:0] wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;
    logic        err_orphan;

    typedef struct {
        logic        vld;
        logic        c;
        logic [15:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic        tag_q[$];
    logic [15:0] model_rd [2];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .c0_req     (c0_req),
        .c0_we      (c0_we),
        .c0_addr    (c0_addr),
        .c0_wdata   (c0_wdata),
        .c0_gnt     (c0_gnt),
        .c0_rdata   (c0_rdata),
        .c0_rvalid  (c0_rvalid),
        .c1_req     (c1_req),
        .c1_we      (c1_we),
        .c1_addr    (c1_addr),
        .c1_wdata   (c1_wdata),
        .c1_gnt     (c1_gnt),
        .c1_rdata   (c1_rdata),
        .c1_rvalid  (c1_rvalid),
        .busy       (busy),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .err_orphan (err_orphan)
    );

    task automatic do_reset;
        reset = 1'b0;
        {c0_req, c0_we, c1_req, c1_we} = '0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        {busy, wr_gnt, rd_gnt, rd_valid} = '0;
        rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        tag_q.delete();
        model_rd[0] = '0;
        model_rd[1] = '0;
    endtask

    // Drive n read returns back to back and check each one a cycle later.
    task automatic return_data(input int n, input logic [15:0] base);
        exp_t e;
        for (int i = 0; i <= n; i++) begin
            @(posedge clk); #1;
            rd_valid = 1'b0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.vld) model_rd[e.c] = e.d;
                n_chk++;
                if ({c1_rvalid, c0_rvalid} !== {e.vld && e.c, e.vld && !e.c}) begin
                    n_fail++;
                    $display("FAIL rvalid: got c1/c0=%b%b want %b%b", c1_rvalid,
                             c0_rvalid, e.vld && e.c, e.vld && !e.c);
                end
                n_chk++;
                if (c0_rdata !== model_rd[0] || c1_rdata !== model_rd[1]) begin
                    n_fail++;
                    $display("FAIL rdata: got %h/%h want %h/%h", c0_rdata, c1_rdata,
                             model_rd[0], model_rd[1]);
                end
            end
            if (i < n) begin
                rd_valid = 1'b1;
                rd_data  = base + 16'(i);
                e.d      = rd_data;
                if (tag_q.size() > 0) begin
                    e.vld = 1'b1;
                    e.c   = tag_q.pop_front();
                end else begin
                    e.vld = 1'b0;
                    e.c   = 1'b0;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // One client issues a single command and is granted when it appears.
    task automatic issue(input logic c, input logic we, input logic [11:0] a,
                         input logic [15:0] d);
        bit done = 0;
        if (c) begin
            c1_req = 1'b1; c1_we = we; c1_addr = a; c1_wdata = d;
        end else begin
            c0_req = 1'b1; c0_we = we; c0_addr = a; c0_wdata = d;
        end
        for (int k = 0; k < 20 && !done; k++) begin
            @(posedge clk); #1;
            if (we ? wr_req : rd_req) begin
                n_chk++;
                if ((we ? wr_addr : rd_addr) !== a) begin
                    n_fail++;
                    $display("FAIL issue_addr: got %h want %h",
                             we ? wr_addr : rd_addr, a);
                end
                if (we) begin
                    n_chk++;
                    if (wr_data !== d) begin
                        n_fail++;
                        $display("FAIL issue_data: got %h want %h", wr_data, d);
                    end
                end
                if (we) wr_gnt = 1'b1; else rd_gnt = 1'b1;
                #1;
                n_chk++;
                if ({c1_gnt, c0_gnt} !== (c ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL issue_gnt: got c1/c0=%b%b want client %0d",
                             c1_gnt, c0_gnt, c);
                end
                if (!we) tag_q.push_back(c);
                done = 1;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL issue_timeout: got no request want client %0d", c);
        end
        @(posedge clk); #1;
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (c) c1_req = 1'b0; else c0_req = 1'b0;
        n_chk++;
        if ({wr_req, rd_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL issue_drop: got wr/rd=%b%b want 00", wr_req, rd_req);
        end
    endtask

    task automatic test_reset;
        do_reset;
        reset = 1'b0;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 12'h3FF;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({wr_req, rd_req, c0_gnt, c1_gnt} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_req: got %b want 0000",
                     {wr_req, rd_req, c0_gnt, c1_gnt});
        end
        n_chk++;
        if ({c0_rvalid, c1_rvalid, err_orphan} !== 3'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000",
                     {c0_rvalid, c1_rvalid, err_orphan});
        end
        n_chk++;
        if ({c0_rdata, c1_rdata} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h want 0", c0_rdata, c1_rdata);
        end
        n_chk++;
        if ({wr_addr, rd_addr, wr_data} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h %h %h want 0", wr_addr, rd_addr, wr_data);
        end
        c0_req = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_write;
        do_reset;
        wr_gnt = 1'b1; rd_gnt = 1'b1;
        #1;
        n_chk++;
        if ({c1_gnt, c0_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_gnt: got %b%b want 00", c1_gnt, c0_gnt);
        end
        wr_gnt = 1'b0; rd_gnt = 1'b0;
        busy = 1'b1;
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 12'h005; c0_wdata = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (wr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_block: got wr_req=%b want 0", wr_req);
        end
        busy = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({wr_req, rd_req, wr_addr, wr_data} !== {2'b10, 12'h005, 16'h1234}) begin
                n_fail++;
                $display("FAIL write_hold%0d: got %b%b %h %h want 10 005 1234", k,
                         wr_req, rd_req, wr_addr, wr_data);
            end
            if (k == 1) begin
                rd_gnt = 1'b1;
                #1;
                n_chk++;
                if (c0_gnt !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrong_type_gnt: got c0_gnt=%b want 0", c0_gnt);
                end
                rd_gnt = 1'b0;
            end
            if (k == 3) wr_gnt = 1'b1;
            #1;
            n_chk++;
            if ({c1_gnt, c0_gnt} !== ((k == 3) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL write_gnt%0d: got %b%b want %b", k, c1_gnt, c0_gnt,
                         (k == 3) ? 2'b01 : 2'b00);
            end
        end
        @(posedge clk); #1;
        wr_gnt = 1'b0; c0_req = 1'b0;
        n_chk++;
        if ({wr_req, c0_gnt} !== 2'b00) begin
            n_fail++;
            $display("FAIL write_drop: got wr_req/c0_gnt=%b%b want 00", wr_req, c0_gnt);
        end
    endtask

    task automatic test_round_robin;
        logic win_q[$];
        logic w;
        int   got = 0;
        do_reset;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        win_q = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        win_q = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 12'h100;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 12'h200;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(posedge clk); #1;
            rd_gnt = 1'b0;
            if (rd_req) begin
                w = win_q.pop_front();
                n_chk++;
                if (rd_addr !== (w ? 12'h200 : 12'h100)) begin
                    n_fail++;
                    $display("FAIL rr_addr%0d: got %h want client %0d", got, rd_addr, w);
                end
                rd_gnt = 1'b1;
                #1;
                n_chk++;
                if ({c1_gnt, c0_gnt} !== (w ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL rr_gnt%0d: got c1/c0=%b%b want client %0d", got,
                             c1_gnt, c0_gnt, w);
                end
                tag_q.push_back(w);
                got++;
            end
        end
        n_chk++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d grants want 4", got);
        end
        @(posedge clk); #1;
        rd_gnt = 1'b0; c0_req = 1'b0; c1_req = 1'b0;
        return_data(4, 16'h0050);
    endtask

    task automatic test_read_return;
        do_reset;
        issue(1'b0, 1'b0, 12'h010, 16'h0);
        issue(1'b1, 1'b0, 12'h011, 16'h0);
        issue(1'b1, 1'b0, 12'h012, 16'h0);
        issue(1'b0, 1'b0, 12'h013, 16'h0);
        return_data(4, 16'h000A);
    endtask

    task automatic test_full;
        bit wgot = 0;
        bit rd_seen = 0;
        do_reset;
        for (int i = 0; i < 4; i++) issue(i[0], 1'b0, 12'h020 + 12'(i), 16'h0);
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 12'h02A;
        c1_req = 1'b1; c1_we = 1'b1; c1_addr = 12'h030; c1_wdata = 16'hBEEF;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            wr_gnt = 1'b0;
            if (wgot) c1_req = 1'b0;
            if (rd_req) rd_seen = 1;
            if (wr_req && !wgot) begin
                n_chk++;
                if ({wr_addr, wr_data} !== {12'h030, 16'hBEEF}) begin
                    n_fail++;
                    $display("FAIL full_wr: got %h %h want 030 beef", wr_addr, wr_data);
                end
                wr_gnt = 1'b1;
                #1;
                n_chk++;
                if ({c1_gnt, c0_gnt} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL full_wgnt: got c1/c0=%b%b want 10", c1_gnt, c0_gnt);
                end
                wgot = 1;
            end
        end
        n_chk++;
        if (wgot !== 1'b1 || rd_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL full_block: got wr=%0d rd=%0d want wr=1 rd=0", wgot, rd_seen);
        end
        return_data(1, 16'h0060);
        issue(1'b0, 1'b0, 12'h02A, 16'h0);
        return_data(4, 16'h0070);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        bit   done = 0;
        do_reset;
        issue(1'b0, 1'b0, 12'h040, 16'h0);
        issue(1'b1, 1'b0, 12'h041, 16'h0);
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 12'h042;
        for (int k = 0; k < 10 && !done; k++) begin
            @(posedge clk); #1;
            if (rd_req) begin
                rd_gnt = 1'b1; rd_valid = 1'b1; rd_data = 16'h0090;
                #1;
                n_chk++;
                if (c0_gnt !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gnt: got c0_gnt=%b want 1", c0_gnt);
                end
                e.vld = 1'b1; e.c = tag_q.pop_front(); e.d = 16'h0090;
                exp_q.push_back(e);
                tag_q.push_back(1'b0);
                done = 1;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL b2b_timeout: got no rd_req want 1");
        end
        @(posedge clk); #1;
        rd_gnt = 1'b0; rd_valid = 1'b0; c0_req = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            model_rd[e.c] = e.d;
            n_chk++;
            if ({c1_rvalid, c0_rvalid, c0_rdata} !== {e.c, !e.c, e.d}) begin
                n_fail++;
                $display("FAIL b2b_ret: got %b%b %h want client %0d %h", c1_rvalid,
                         c0_rvalid, c0_rdata, e.c, e.d);
            end
        end
        return_data(2, 16'h00A0);
    endtask

    task automatic test_orphan_reset;
        bit seen = 0;
        do_reset;
        return_data(1, 16'h0033);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (err_orphan !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_sticky: got %b want 1", err_orphan);
        end
        do_reset;
        issue(1'b1, 1'b0, 12'h055, 16'h0);
        c0_req = 1'b1; c0_we = 1'b1; c0_addr = 12'h066; c0_wdata = 16'h6666;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk); #1;
            if (wr_req) seen = 1;
        end
        reset = 1'b0; c0_req = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if ({seen, wr_req, rd_req, err_orphan, c0_gnt} !== 5'b10000) begin
            n_fail++;
            $display("FAIL issue_reset: got seen/wr/rd/err/gnt=%b want 10000",
                     {seen, wr_req, rd_req, err_orphan, c0_gnt});
        end
        reset = 1'b1;
        tag_q.delete();
        return_data(1, 16'h0077);
        n_chk++;
        if (err_orphan !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_after_reset: got %b want 1", err_orphan);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_round_robin;
        test_read_return;
        test_full;
        test_back_to_back;
        test_orphan_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
